hazard_ctrl_unit: RTL and testbench

// - Pipeline sequencer for the 5-stage core (F,D,E,M,W). Generates stall/flush for F/D, D/E, E/M and M/W pipeline regs,
//   E-stage forwarding selects, and a dmem-wait FSM with watchdog. Sole driver of regStall/flush of every stage register.

---
 rtl/core_pkg.sv | 11 +
 rtl/fwd_sel.sv | 24 ++
 rtl/hazard_ctrl_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared pipeline types and constants for the 5-stage core.
//   stage_state_t  : dmem-wait sequencer states (RUN, DWAIT, ERR)
//   FWD_RF/M/W     : E-stage operand forwarding selects
//   DEF_REG_ADDR_W : default register index width
package core_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, ERR} stage_state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam int DEF_REG_ADDR_W = 5;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: combinational forwarding select for one E-stage source operand.
//   i_rs                       : source register of the operand in E
//   i_rd_M, i_regwrite_M       : M-stage destination and write enable
//   i_rd_W, i_regwrite_W       : W-stage destination and write enable
//   o_fwd                      : FWD_M, FWD_W or FWD_RF
module fwd_sel
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rd_M,
  input  logic [REG_ADDR_W-1:0] i_rd_W,
  input  logic                  i_regwrite_M,
  input  logic                  i_regwrite_W,
  output logic [1:0]            o_fwd
);
  logic w_hit_M, w_hit_W;
  // x0 is hardwired zero, so a write to it never produces a forwardable value
  assign w_hit_M = i_regwrite_M && (i_rd_M != '0) && (i_rd_M == i_rs);
  assign w_hit_W = i_regwrite_W && (i_rd_W != '0) && (i_rd_W == i_rs);
  // M holds the younger result, so it beats W
  assign o_fwd = w_hit_M ? FWD_M : (w_hit_W ? FWD_W : FWD_RF);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline sequencer for the F/D/E/M/W core.
//   clk, reset_n            : clock, asynchronous active-low reset
//   i_rs1_D/i_rs2_D         : sources of the instruction in D
//   i_rs1_E/i_rs2_E/i_rd_E  : sources/destination of the instruction in E
//   i_rd_M/i_rd_W           : destinations in M and W
//   i_memread_E             : instruction in E is a load
//   i_regwrite_M/W          : destination write enables
//   i_pcsrc_E               : taken branch/jump resolved in E
//   i_imem_ready            : fetch data valid
//   i_dmem_req_M/ready      : M-stage data memory handshake
//   i_err_clr               : clears the watchdog error
//   o_stall_F/D/E/M         : hold PC / stage registers
//   o_flush_D/E/W           : bubble stage registers
//   o_fwdA_E/o_fwdB_E       : E-stage forwarding selects
//   o_mem_timeout           : sticky dmem watchdog error
//   o_stall_cnt/flush_cnt   : saturating perf counters
module hazard_ctrl_unit
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] i_rs1_D,
  input  logic [REG_ADDR_W-1:0] i_rs2_D,
  input  logic [REG_ADDR_W-1:0] i_rs1_E,
  input  logic [REG_ADDR_W-1:0] i_rs2_E,
  input  logic [REG_ADDR_W-1:0] i_rd_E,
  input  logic [REG_ADDR_W-1:0] i_rd_M,
  input  logic [REG_ADDR_W-1:0] i_rd_W,
  input  logic                  i_memread_E,
  input  logic                  i_regwrite_M,
  input  logic                  i_regwrite_W,
  input  logic                  i_pcsrc_E,
  input  logic                  i_imem_ready,
  input  logic                  i_dmem_req_M,
  input  logic                  i_dmem_ready,
  input  logic                  i_err_clr,
  output logic                  o_stall_F,
  output logic                  o_stall_D,
  output logic                  o_stall_E,
  output logic                  o_stall_M,
  output logic                  o_flush_D,
  output logic                  o_flush_E,
  output logic                  o_flush_W,
  output logic [1:0]            o_fwdA_E,
  output logic [1:0]            o_fwdB_E,
  output logic                  o_mem_timeout,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);
  localparam int WC_W = $clog2(TIMEOUT);

  stage_state_t        r_state, w_state_nxt;
  logic [WC_W-1:0]     r_wait_cnt;
  logic                r_mem_timeout;
  logic [CNT_W-1:0]    r_stall_cnt, r_flush_cnt;
  logic [1:0]          w_fwdA, w_fwdB;
  logic                w_dwait, w_freeze, w_load_use, w_timeout_hit, w_branch;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs(i_rs1_E), .i_rd_M(i_rd_M), .i_rd_W(i_rd_W),
    .i_regwrite_M(i_regwrite_M), .i_regwrite_W(i_regwrite_W), .o_fwd(w_fwdA)
  );
  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs(i_rs2_E), .i_rd_M(i_rd_M), .i_rd_W(i_rd_W),
    .i_regwrite_M(i_regwrite_M), .i_regwrite_W(i_regwrite_W), .o_fwd(w_fwdB)
  );

  assign w_dwait       = i_dmem_req_M && !i_dmem_ready;
  assign w_freeze      = (r_state == ERR) || w_dwait;
  assign w_load_use    = i_memread_E && (i_rd_E != '0) && ((i_rd_E == i_rs1_D) || (i_rd_E == i_rs2_D));
  assign w_timeout_hit = (r_state == DWAIT) && !i_dmem_ready && (r_wait_cnt == WC_W'(TIMEOUT - 1));
  // a branch only redirects when the pipe is not frozen; otherwise it waits in E
  assign w_branch      = !w_freeze && i_pcsrc_E;

  // outputs are forced to their idle values while reset is held
  always_comb begin
    o_stall_F = 1'b0;
    o_stall_D = 1'b0;
    o_stall_E = 1'b0;
    o_stall_M = 1'b0;
    o_flush_D = 1'b0;
    o_flush_E = 1'b0;
    o_flush_W = 1'b0;
    o_fwdA_E  = reset_n ? w_fwdA : FWD_RF;
    o_fwdB_E  = reset_n ? w_fwdB : FWD_RF;
    if (!reset_n) begin
      o_stall_F = 1'b0;
    end else if (w_freeze) begin
      o_stall_F = 1'b1;
      o_stall_D = 1'b1;
      o_stall_E = 1'b1;
      o_stall_M = 1'b1;
      o_flush_W = 1'b1;
    end else if (i_pcsrc_E) begin
      o_flush_D = 1'b1;
      o_flush_E = 1'b1;
    end else if (w_load_use) begin
      o_stall_F = 1'b1;
      o_stall_D = 1'b1;
      o_flush_E = 1'b1;
    end else if (!i_imem_ready) begin
      o_stall_F = 1'b1;
      o_flush_D = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     w_state_nxt = w_dwait ? DWAIT : RUN;
      // a clear arriving with the timeout suppresses the error entirely
      DWAIT:   w_state_nxt = i_dmem_ready ? RUN : (w_timeout_hit ? (i_err_clr ? RUN : ERR) : DWAIT);
      ERR:     w_state_nxt = i_err_clr ? RUN : ERR;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= (r_state == DWAIT) ? r_wait_cnt + 1'b1 : '0;
      r_mem_timeout <= i_err_clr ? 1'b0 : (r_mem_timeout || (w_state_nxt == ERR && r_state == DWAIT));
      if (o_stall_F && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_branch && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: scoreboard bench for hazard_ctrl_unit.
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic memread_E, regwrite_M, regwrite_W, pcsrc_E, imem_ready, dmem_req_M, dmem_ready, err_clr;
  logic stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_timeout;
  logic [1:0] fwdA_E, fwdB_E;
  logic [31:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;
  logic [10:0] exp_q[$];
  string tag_q[$];

  // expected vector: {stall_F,D,E,M, flush_D,E,W, fwdA, fwdB}
  localparam logic [10:0] IDLE = 11'b0000_000_00_00;
  localparam logic [10:0] FRZ  = 11'b1111_001_00_00;
  localparam logic [10:0] LU   = 11'b1100_010_00_00;
  localparam logic [10:0] BR   = 11'b0000_110_00_00;
  localparam logic [10:0] IMW  = 11'b1000_100_00_00;

  always #5 clk = ~clk;

  hazard_ctrl_unit dut (
    .clk(clk), .reset_n(reset_n),
    .i_rs1_D(rs1_D), .i_rs2_D(rs2_D), .i_rs1_E(rs1_E), .i_rs2_E(rs2_E),
    .i_rd_E(rd_E), .i_rd_M(rd_M), .i_rd_W(rd_W),
    .i_memread_E(memread_E), .i_regwrite_M(regwrite_M), .i_regwrite_W(regwrite_W),
    .i_pcsrc_E(pcsrc_E), .i_imem_ready(imem_ready), .i_dmem_req_M(dmem_req_M),
    .i_dmem_ready(dmem_ready), .i_err_clr(err_clr),
    .o_stall_F(stall_F), .o_stall_D(stall_D), .o_stall_E(stall_E), .o_stall_M(stall_M),
    .o_flush_D(flush_D), .o_flush_E(flush_E), .o_flush_W(flush_W),
    .o_fwdA_E(fwdA_E), .o_fwdB_E(fwdB_E), .o_mem_timeout(mem_timeout),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    memread_E = 0; regwrite_M = 0; regwrite_W = 0; pcsrc_E = 0;
    imem_ready = 1; dmem_req_M = 0; dmem_ready = 0; err_clr = 0;
  endtask

  task automatic push(input string tag, input logic [10:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sample();
    logic [10:0] e;
    string t;
    if (exp_q.size() == 0) begin
      chk("scoreboard empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, 32'({stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, fwdA_E, fwdB_E}), 32'(e));
  endtask

  // called at a negedge with inputs set; returns at the next negedge
  task automatic cyc(input string tag, input logic [10:0] e);
    push(tag, e);
    #2 sample();
    @(posedge clk);
    if (e[10] && exp_stall != '1) exp_stall++;
    if (e[6] && e[5] && exp_flush != '1) exp_flush++;
    #1;
    chk({tag, " stall_cnt"}, stall_cnt, exp_stall);
    chk({tag, " flush_cnt"}, flush_cnt, exp_flush);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset_n = 0;
    idle();
    @(negedge clk);
    push("reset outputs", IDLE);
    #1 sample();
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset flush_cnt", flush_cnt, 0);
    chk("reset timeout", 32'(mem_timeout), 0);
    @(negedge clk);
    reset_n = 1;
    cyc("idle", IDLE);
    memread_E = 1; rd_E = 5; rs1_D = 5;
    cyc("load-use rs1", LU);
    rd_E = 0;
    cyc("after bubble", IDLE);
    rd_E = 7; rs1_D = 0; rs2_D = 7;
    cyc("load-use rs2", LU);
    rd_E = 0; rs2_D = 0;
    cyc("load rd0 no stall", IDLE);
    idle();
    imem_ready = 0;
    cyc("imem wait", IMW);
    idle();
    regwrite_M = 1; regwrite_W = 1; rd_M = 3; rd_W = 3; rs1_E = 3;
    cyc("fwdA M beats W", 11'b0000_000_10_00);
    rd_M = 0; rs2_E = 3;
    cyc("fwdA W when rd_M 0", 11'b0000_000_01_01);
    regwrite_W = 0; rd_M = 3; regwrite_M = 0;
    cyc("no regwrite", IDLE);
    regwrite_M = 1; regwrite_W = 1; rd_W = 0; rs2_E = 0;
    cyc("fwdB rf rd_W 0", 11'b0000_000_10_00);
    idle();
    pcsrc_E = 1; memread_E = 1; rd_E = 4; rs1_D = 4; imem_ready = 0;
    cyc("branch beats load-use", BR);
    idle();
    dmem_req_M = 1; dmem_ready = 0;
    cyc("dwait 1", FRZ);
    pcsrc_E = 1;
    cyc("dwait 2 branch held", FRZ);
    cyc("dwait 3 branch held", FRZ);
    dmem_ready = 1;
    cyc("dmem done branch", BR);
    pcsrc_E = 0;
    cyc("ready first cycle", IDLE);
    dmem_ready = 0;
    for (int i = 0; i < 17; i++) begin
      cyc("timeout wait", FRZ);
      chk("timeout flag", 32'(mem_timeout), 32'(i == 16));
    end
    dmem_req_M = 0;
    cyc("err hold", FRZ);
    chk("err sticky", 32'(mem_timeout), 1);
    err_clr = 1;
    cyc("err clr cycle", FRZ);
    chk("err cleared", 32'(mem_timeout), 0);
    err_clr = 0;
    cyc("run after clr", IDLE);
    dmem_req_M = 1;
    for (int i = 0; i < 16; i++) cyc("timeout2 wait", FRZ);
    err_clr = 1;
    cyc("clr with timeout", FRZ);
    chk("clr wins flag", 32'(mem_timeout), 0);
    err_clr = 0; dmem_req_M = 0;
    cyc("clr wins run", IDLE);
    dmem_req_M = 1;
    cyc("pre-reset wait 1", FRZ);
    cyc("pre-reset wait 2", FRZ);
    pcsrc_E = 1;
    reset_n = 0;
    push("reset mid wait", IDLE);
    #1 sample();
    chk("async stall_cnt", stall_cnt, 0);
    chk("async flush_cnt", flush_cnt, 0);
    exp_stall = 0;
    exp_flush = 0;
    @(posedge clk);
    @(negedge clk);
    dmem_req_M = 0;
    reset_n = 1;
    cyc("branch after release", BR);
    pcsrc_E = 0;
    cyc("final idle", IDLE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
